// File: rtl/nf10_rx_len_tagger_pkg.sv
// Shared tuser field offsets, write-FSM states and strobe helpers for the RX length tagger.
package nf10_rx_len_tagger_pkg;

  localparam int LEN_LO = 0;
  localparam int LEN_HI = 15;
  localparam int SRC_LO = 16;
  localparam int SRC_HI = 23;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

  function automatic logic [3:0] strb_bytes(input logic [7:0] strb);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, strb[i]};
    return n;
  endfunction

  // Last-beat strobe from the low length bits; a multiple of 8 bytes fills the word.
  function automatic logic [7:0] last_strb(input logic [2:0] len_lo);
    logic [7:0] s;
    s = 8'hFF;
    if (len_lo != 3'd0) s = 8'hFF >> (4'd8 - {1'b0, len_lo});
    return s;
  endfunction

endpackage

// File: rtl/nf10_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head word visible on rd_dat_o while rd_vld_o, zero-cycle read latency.
// Write side is refused (wr_rdy_o=0) when full; read side pops on rd_vld_o && rd_rdy_i.
module nf10_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         wr_rdy_o,
  output logic         rd_vld_o,
  output logic [W-1:0] rd_dat_o,
  input  logic         rd_rdy_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  assign wr_rdy_o = (wr_ptr_q - rd_ptr_q) != FULL_CNT;
  assign rd_vld_o = wr_ptr_q != rd_ptr_q;
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_vld_i && wr_rdy_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_vld_i && wr_rdy_o) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_rdy_i && rd_vld_o) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/nf10_rx_len_tagger.sv
// Store-and-forward RX stage: buffers each packet, tags tuser with byte length and source port, drops whole packets on overflow.
// First beat out 2 cycles after input tlast; input never back-pressured. NF10_RX_LEN_TAGGER_STATS_EN adds pkt_cnt/drop_cnt.
module nf10_rx_len_tagger
  import nf10_rx_len_tagger_pkg::*;
#(
  parameter int         C_AXIS_DATA_WIDTH  = 64,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_SRC_PORT         = 8'h01,
  parameter int         C_DATA_DEPTH       = 512,
  parameter int         C_META_DEPTH       = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [7:0]                    s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [7:0]                    m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
`ifdef NF10_RX_LEN_TAGGER_STATS_EN
  ,
  output logic [31:0]                   pkt_cnt,
  output logic [31:0]                   drop_cnt
`endif
);
  localparam int AW = $clog2(C_DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = $clog2(C_META_DEPTH) + 1;
  localparam logic [PW-1:0] DATA_FULL = PW'(C_DATA_DEPTH);
  localparam logic [MW-1:0] META_FULL = MW'(C_META_DEPTH);

  logic [C_AXIS_DATA_WIDTH-1:0] buf_q [C_DATA_DEPTH];
  logic [PW-1:0] wr_ptr_q, start_ptr_q, rd_ptr_q;
  wr_state_e     wr_state_q;
  logic [15:0]   byte_cnt_q, len_d;
  logic [MW-1:0] pend_q;
  logic          data_full, meta_full, buf_we, commit, drop_start, rewind, pkt_done;
  logic          meta_wr_rdy, meta_rd_vld, meta_pop;
  logic [15:0]   meta_len;
  logic [13:0]   meta_words;

  logic          rd_active_q, can_load, rd_last;
  logic [15:0]   rd_len_q;
  logic [13:0]   rd_words_q, rd_beat_q;
  logic          out_vld_q, out_last_q;
  logic [C_AXIS_DATA_WIDTH-1:0] out_dat_q;
  logic [7:0]    out_strb_q, out_src_q;
  logic [15:0]   out_len_q;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  assign s_axis_tready = 1'b1;
  assign data_full = (wr_ptr_q - rd_ptr_q) == DATA_FULL;
  // Packets still held anywhere downstream (queue, read setup, output register) count against the metadata depth.
  assign meta_full = (pend_q == META_FULL) || !meta_wr_rdy;
  assign len_d = ((wr_state_q == WR_WRITE) ? byte_cnt_q : 16'd0) + {12'd0, strb_bytes(s_axis_tstrb)};
  assign pkt_done = out_vld_q && m_axis_tready && out_last_q;

  always_comb begin
    buf_we     = 1'b0;
    commit     = 1'b0;
    drop_start = 1'b0;
    rewind     = 1'b0;
    if (s_axis_tvalid) begin
      case (wr_state_q)
        WR_IDLE: begin
          if (meta_full || data_full) drop_start = 1'b1;
          else begin
            buf_we = 1'b1;
            commit = s_axis_tlast;
          end
        end
        WR_WRITE: begin
          if (data_full) begin
            drop_start = 1'b1;
            rewind     = 1'b1;
          end else begin
            buf_we = 1'b1;
            commit = s_axis_tlast;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      wr_state_q  <= WR_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      byte_cnt_q  <= '0;
    end else begin
      if (buf_we) begin
        wr_ptr_q   <= wr_ptr_q + PW'(1);
        byte_cnt_q <= len_d;
      end
      if (commit) start_ptr_q <= wr_ptr_q + PW'(1);
      if (rewind) wr_ptr_q <= start_ptr_q;
      if (s_axis_tvalid) begin
        case (wr_state_q)
          WR_IDLE:  if (!s_axis_tlast) wr_state_q <= drop_start ? WR_DROP : WR_WRITE;
          WR_WRITE: begin
            if (s_axis_tlast)    wr_state_q <= WR_IDLE;
            else if (drop_start) wr_state_q <= WR_DROP;
          end
          default:  if (s_axis_tlast) wr_state_q <= WR_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (buf_we) buf_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) pend_q <= '0;
    else           pend_q <= pend_q + MW'(commit) - MW'(pkt_done);
  end

  nf10_sync_fifo #(
    .W     (16),
    .DEPTH (C_META_DEPTH)
  ) u_meta_fifo (
    .clk_i    (axi_aclk),
    .rst_i    (axi_reset),
    .wr_vld_i (commit),
    .wr_dat_i (len_d),
    .wr_rdy_o (meta_wr_rdy),
    .rd_vld_o (meta_rd_vld),
    .rd_dat_o (meta_len),
    .rd_rdy_i (meta_pop)
  );

  assign meta_words = {1'b0, meta_len[15:3]} + {13'd0, |meta_len[2:0]};
  assign can_load   = !out_vld_q || m_axis_tready;
  assign rd_last    = (rd_beat_q + 14'd1) >= rd_words_q;
  // The next packet is set up while the current last beat loads, so packets stream without a bubble.
  assign meta_pop   = meta_rd_vld && (!rd_active_q || (can_load && rd_last));

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      rd_active_q <= 1'b0;
      rd_ptr_q    <= '0;
      rd_len_q    <= '0;
      rd_words_q  <= '0;
      rd_beat_q   <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_dat_q   <= '0;
      out_strb_q  <= '0;
      out_len_q   <= '0;
      out_src_q   <= '0;
    end else begin
      if (rd_active_q && can_load) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= buf_q[rd_ptr_q[AW-1:0]];
        out_strb_q <= rd_last ? last_strb(rd_len_q[2:0]) : 8'hFF;
        out_last_q <= rd_last;
        out_len_q  <= rd_len_q;
        out_src_q  <= C_SRC_PORT;
        rd_ptr_q   <= rd_ptr_q + PW'(1);
        rd_beat_q  <= rd_beat_q + 14'd1;
        if (rd_last) rd_active_q <= 1'b0;
      end else if (can_load) begin
        out_vld_q <= 1'b0;
      end
      if (meta_pop) begin
        rd_active_q <= 1'b1;
        rd_len_q    <= meta_len;
        rd_words_q  <= meta_words;
        rd_beat_q   <= '0;
      end
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_dat_q;
  assign m_axis_tstrb  = out_strb_q;
  assign m_axis_tlast  = out_last_q;

  always_comb begin
    m_axis_tuser = '0;
    m_axis_tuser[LEN_HI:LEN_LO] = out_len_q;
    m_axis_tuser[SRC_HI:SRC_LO] = out_src_q;
  end

`ifdef NF10_RX_LEN_TAGGER_STATS_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit && (pkt_cnt != '1))      pkt_cnt  <= pkt_cnt + 32'd1;
      if (drop_start && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/nf10_rx_len_tagger.md
Name: nf10_rx_len_tagger

Overview:
- Store-and-forward stage directly downstream of the 10G interface master AXI-Stream output (m_axis, 64-bit data, 128-bit tuser).
- Buffers each received packet until its last beat and counts its bytes.
- Emits the packet with NetFPGA metadata in tuser: length in bytes and source port.
- Drops a packet whole when buffering cannot hold it, because the MAC receive path cannot be back-pressured.

Parameters:
- C_AXIS_DATA_WIDTH, 64: data width. Only 64 is supported; the strobe is 8 bits.
- C_AXIS_TUSER_WIDTH, 128: tuser width on both sides.
- C_SRC_PORT, 8'h01: one-hot source-port code written to tuser[23:16].
- C_DATA_DEPTH, 512: data buffer depth in 64-bit words. Must be a power of two.
- C_META_DEPTH, 16: metadata FIFO depth in packets. Must be a power of two.

Ports:
- axi_aclk  in  1  single clock for the block.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  receive data from the 10G interface.
- s_axis_tstrb  in  8  byte strobe. Must be 8'hFF on non-last beats. Must be contiguous from bit 0 on the last beat.
- s_axis_tuser  in  128  ignored.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  held at 1 (never back-pressures).
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  64  output data.
- m_axis_tstrb  out  8  output byte strobe.
- m_axis_tuser  out  128  output metadata: [15:0] length in bytes, [23:16] C_SRC_PORT, [127:24] zero.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.

Behaviour:
- Reset: all outputs 0 except s_axis_tready=1. Pointers cleared, metadata FIFO empty, write FSM in IDLE.
- Reset is synchronous and applies mid-packet. A partial input packet is discarded. An output packet in flight is truncated (m_axis_tvalid=0 the cycle after reset). After reset, the next accepted beat is treated as a packet start.
- Write FSM, IDLE:
  - Beat accepted, metadata FIFO full → DROP.
  - Beat accepted, otherwise → store the beat; go to WRITE if tlast=0.
  - Beat accepted with tlast=1 and space available → commit as a 1-beat packet, stay in IDLE.
- Write FSM, WRITE: store the beat and accumulate bytes. On tlast → commit, go to IDLE.
- Write FSM, DROP: discard beats. On tlast → IDLE.
- Byte count per beat = popcount(tstrb), accumulated in 16 bits.
- Data-full handling:
  - If a beat arrives when the buffer is full, the write pointer rewinds to the packet start.
  - The partial packet is discarded and the FSM goes to DROP. If that beat has tlast, go directly to IDLE.
  - Free space is computed from the registered read pointer. A read in the same cycle frees space from the next cycle only.
- Commit, on the last-beat handshake:
  - Push the 16-bit byte length to the metadata FIFO.
  - Advance the committed write pointer.
  - The read side never sees uncommitted words.
- Read side:
  - Pops metadata and computes word count = ceil(len/8).
  - Streams words through a registered output stage.
  - tuser is constant for the whole packet.
  - m_axis_tstrb = 8'hFF except on the last beat, which decodes len[2:0] (0 → 8'hFF).
  - m_axis_tlast is asserted on beat word count.
- Latency: first output beat valid exactly 2 cycles after the input last-beat handshake, when the output is idle and ready.
- Output throughput: 1 beat per cycle while m_axis_tready=1. Back-to-back packets have no bubble.
- AXI rule: once m_axis_tvalid is asserted, tdata, tstrb, tuser and tlast hold until the handshake.

Optional Feature:
- Macro NF10_RX_LEN_TAGGER_STATS_EN adds two outputs:
  - pkt_cnt [31:0]: committed packets.
  - drop_cnt [31:0]: packets entering DROP or rewound.
- Both counters saturate and reset to 0.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Package nf10_rx_len_tagger_pkg holds:
  - tuser field offsets: LEN_LO=0, LEN_HI=15, SRC_LO=16, SRC_HI=23.
  - write-FSM state enum.
  - strobe-decode function.
- Sub-module nf10_sync_fifo: generic show-ahead synchronous FIFO, used for the metadata queue.
- The data buffer with rewind stays in the top module.

Test Plan:
- 64-byte packet (8 beats, last tstrb FF), m_axis_tready=1 → 8 output beats; tuser[15:0]=16'h0040, tuser[23:16]=C_SRC_PORT; tlast on beat 8; first tvalid 2 cycles after input tlast.
- 61-byte packet (last tstrb 8'h1F) → length 16'h003D; last output tstrb 8'h1F; data bit-exact.
- m_axis_tready low for 200 cycles while three packets of 8, 1 and 20 beats arrive → all delivered in order, no loss, no bubbles once ready rises.
- m_axis_tready low, a 600-beat packet then an 8-beat packet → first packet dropped, second delivered intact; drop_cnt=1, pkt_cnt=1 with the macro.
- m_axis_tready low, 17 single-beat packets → the 17th is dropped and the first 16 are delivered.
- Reset asserted mid-output of a 20-beat packet → m_axis_tvalid=0 the next cycle; buffers empty; a following 8-beat packet is delivered correctly.
